spi_multi_lane_rx: RTL and testbench
====================================

# spi_multi_lane_rx

Parametrised multi-lane SPI slave receiver for board-to-board transfer of simulation state (muscle length, force, firing rate) between XEM6010 boards. It runs entirely in the `clk1` domain: it oversamples SCK/SSEL/DATA, shifts `NCH` lanes of `W` bits in parallel and validates frame length. It commits every lane atomically and reports frame errors. It replaces the fixed 2×32-bit slave and removes the need for downstream ad-hoc resynchronisation registers.

## Interface
- `NCH`, 2, number of parallel data lanes sharing one SCK/SSEL.
- `W`, 32, bits per lane per frame (valid range 8..64).
- `SYNC_STAGES`, 2, synchroniser flops on SCK, SSEL and DATA_IN (minimum 2).
- `MSB_FIRST`, 1; 1 means the first received bit lands in bit W-1, 0 means it lands in bit 0.

- `clk`, in, 1, system clock (clk1); all logic is on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `en`, in, 1, receive enable; sampled only in IDLE.
- `SCK`, in, 1, SPI clock from the remote master (mode 0; sample on rising edge).
- `SSEL`, in, 1, frame select, active-low.
- `DATA_IN`, in, NCH, one serial line per lane.
- `rx_out`, out, NCH*W, last good frame; lane k is `rx_out[k*W +: W]`.
- `rdy`, out, 1, one-cycle pulse when `rx_out` updates.
- `frame_err`, out, 1, one-cycle pulse when a frame is discarded.
- `frame_cnt`, out, 16, good frames since reset; wraps.
- `err_cnt`, out, 16, bad frames since reset; saturates at 0xFFFF.

## Operation
- Synchronisation: SCK, SSEL and DATA_IN each pass through `SYNC_STAGES` flops, followed by one history flop per signal. Edges are detected from the synchronised and history values.
- State machine states: IDLE, SHIFT, COMMIT.
- IDLE → SHIFT on a synchronised SSEL falling edge with `en`=1. On entry, `bit_cnt` is cleared and the shift registers are cleared.
- SHIFT, on each synchronised SCK rising edge:
  - every lane shifts in its synchronised DATA bit (direction set by MSB_FIRST);
  - `bit_cnt` increments and saturates at W+1.
- SHIFT → COMMIT on a synchronised SSEL rising edge.
- COMMIT lasts one cycle:
  - if `bit_cnt`==W: `rx_out` is loaded from all shift registers in the same cycle, `rdy`=1, and `frame_cnt`++;
  - otherwise: `rx_out` holds its value, `frame_err`=1, and `err_cnt` increments (saturating).
  - The state then returns to IDLE.
- If an SCK rise and an SSEL rise land in the same cycle, the SCK bit is shifted first, then the frame ends. `bit_cnt` includes that bit.
- An SSEL fall while in SHIFT (glitch) restarts the frame and leaves the counters unchanged.
- An SSEL fall in COMMIT is honoured on the following IDLE cycle, because the edge flag is held for one cycle.
- `en` falling mid-frame has no effect until the frame ends. While `en`=0, frames are ignored entirely and no counters move.
- Reset:
  - `rx_out`=0, `rdy`=0, `frame_err`=0, `frame_cnt`=0, `err_cnt`=0;
  - state is IDLE and the synchroniser flops are cleared to SCK=0, SSEL=1, DATA=0.
  - Reset mid-frame aborts the frame; reception resumes only at the next SSEL fall.

## Timing
- Latency from the physical SSEL rise to `rdy` is SYNC_STAGES+2 clk cycles (sync, edge detect, COMMIT).
- `rx_out` changes only in the cycle where `rdy`=1, and is stable at all other times.
- `rdy` and `frame_err` are never high in the same cycle.
- Minimum SCK high time and low time is SYNC_STAGES+1 clk cycles each. clkdiv=13 on the master satisfies this.
- Minimum SSEL high time between frames is SYNC_STAGES+3 cycles.
- Consumers in a slower domain sample `rx_out` after `rdy`; no further resynchronisation is required.

## Structure
- Shared package `spi_link_pkg`:
  - state enum {IDLE, SHIFT, COMMIT};
  - `SPI_MODE` = 0;
  - the counter width constant (16).
  The spi_master successor uses the same package.
- Sub-module `spi_edge_sync`: a parametrised synchroniser plus rise/fall detector. It is instantiated for SCK and SSEL; DATA uses the synchroniser only.
- Lanes are built with a generate loop over NCH shift registers. There is one shared `bit_cnt`, sized `$clog2(W+2)`.

## Test plan
- Good frame (NCH=2, W=32, MSB_FIRST=1): lane0 carries 0x3F800000 and lane1 carries 0x42A00000. Expect `rx_out`={0x42A00000, 0x3F800000}, exactly one `rdy` pulse SYNC_STAGES+2 cycles after the SSEL rise, and `frame_cnt`=1.
- Short frame (31 SCK edges), then long frame (33 SCK edges): expect two `frame_err` pulses, `err_cnt`=2, and `rx_out` unchanged from the previous good value.
- Reset asserted after bit 16 of a frame, followed by a clean frame 0x12345678/0x9ABCDEF0: expect all outputs 0 after reset, then correct data with `frame_cnt`=1.
- `en`=0 during a full valid frame: expect no `rdy`, no `frame_err`, and both counters unchanged. Then `en`=1 with a valid frame: normal commit.
- Back-to-back frames with the minimum SSEL gap, carrying 0x00000001 then 0xFFFFFFFF on lane0: expect two `rdy` pulses and final lane0=0xFFFFFFFF.
- MSB_FIRST=0, W=16, NCH=4, with bit pattern 1,0,0,...,0 on lane3: expect lane3=0x0001 and all other lanes correct.

Source files
------------

// File: rtl/spi_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_link_pkg
//  Description : Definitions shared by the board-to-board SPI link blocks
//                (receiver and master). Holds the link FSM state encoding,
//                the SPI mode and the width of the frame/error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_link_pkg;

    localparam int SPI_MODE = 0;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_edge_sync
//  Description : Multi-flop synchroniser for one asynchronous input followed
//                by a history flop. Reports the synchronised level and a
//                one-cycle change strobe; the direction of a change is the
//                new level (change & level = rise, change & ~level = fall).
//  Ports       : clk    - system clock
//                reset  - synchronous, active-high; loads RST_VAL everywhere
//                din    - asynchronous input
//                level  - synchronised value of din
//                toggle - high for one cycle when level differs from history
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_edge_sync
    import spi_link_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic toggle
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RST_VAL}};
            hist  <= RST_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            hist  <= chain[SYNC_STAGES-1];
        end
    end

    assign level  = chain[SYNC_STAGES-1];
    assign toggle = chain[SYNC_STAGES-1] ^ hist;

endmodule
`default_nettype wire

// File: rtl/spi_multi_lane_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_multi_lane_rx
//  Description : Multi-lane SPI (mode 0) slave receiver running entirely in
//                the system clock domain. SCK, SSEL and DATA_IN are
//                oversampled; NCH lanes of W bits are shifted in parallel,
//                the frame length is validated and all lanes are committed
//                to rx_out atomically. Bad-length frames are discarded.
//  Ports       : clk, reset      - system clock, synchronous active-high reset
//                en              - receive enable, only looked at in IDLE
//                SCK, SSEL       - SPI clock / active-low frame select
//                DATA_IN[NCH]    - one serial line per lane
//                rx_out[NCH*W]   - last good frame, lane k at [k*W +: W]
//                rdy             - one-cycle pulse when rx_out updates
//                frame_err       - one-cycle pulse when a frame is dropped
//                frame_cnt       - good frames since reset (wraps)
//                err_cnt         - bad frames since reset (saturates)
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_multi_lane_rx
    import spi_link_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 SCK,
    input  logic                 SSEL,
    input  logic [NCH-1:0]       DATA_IN,
    output logic [NCH*W-1:0]     rx_out,
    output logic                 rdy,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int              BC_W    = $clog2(W + 2);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(W);
    localparam logic [BC_W-1:0] BC_SAT  = BC_W'(W + 1);

    // ---------------------------------------------------------------- sync
    logic sck_lvl, sck_tog, ssel_lvl, ssel_tog;
    logic sck_rise, ssel_rise, ssel_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (SCK),
        .level  (sck_lvl),
        .toggle (sck_tog)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ssel_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (SSEL),
        .level  (ssel_lvl),
        .toggle (ssel_tog)
    );

    assign sck_rise  = sck_tog & sck_lvl;
    assign ssel_rise = ssel_tog & ssel_lvl;
    assign ssel_fall = ssel_tog & ~ssel_lvl;

    // DATA goes through the same depth as SCK so a bit is aligned with
    // the SCK rise that samples it; no edge detection is needed here.
    logic [NCH-1:0] data_sync [SYNC_STAGES];
    logic [NCH-1:0] data_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
        end else begin
            data_sync[0] <= DATA_IN;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
        end
    end

    assign data_s = data_sync[SYNC_STAGES-1];

    // ---------------------------------------------------------- lane shift
    logic [NCH*W-1:0] shreg;
    logic [NCH*W-1:0] shreg_nxt;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        if (MSB_FIRST) begin : g_msb
            assign shreg_nxt[k*W +: W] = {shreg[k*W +: W-1], data_s[k]};
        end else begin : g_lsb
            assign shreg_nxt[k*W +: W] = {data_s[k], shreg[k*W+1 +: W-1]};
        end
    end

    // ----------------------------------------------------------------- FSM
    spi_state_t      state, state_nxt;
    logic [BC_W-1:0] bit_cnt;
    logic            fall_pend;
    logic            clear, shift_en, commit_ok, commit_bad;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        clear      = 1'b0;
        shift_en   = 1'b0;
        commit_ok  = 1'b0;
        commit_bad = 1'b0;
        case (state)
            IDLE: begin
                // fall_pend carries an SSEL fall that arrived during COMMIT
                if (en && (ssel_fall || fall_pend)) begin
                    state_nxt = SHIFT;
                    clear     = 1'b1;
                end
            end
            SHIFT: begin
                if (ssel_fall) begin
                    clear = 1'b1;
                end else begin
                    // a coincident SCK rise is shifted before the frame ends
                    shift_en = sck_rise;
                    if (ssel_rise) state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                state_nxt = IDLE;
                if (bit_cnt == BC_FULL) commit_ok  = 1'b1;
                else                    commit_bad = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            fall_pend <= 1'b0;
            rx_out    <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            rdy       <= commit_ok;
            frame_err <= commit_bad;
            fall_pend <= (state == COMMIT) && ssel_fall;

            if (clear) begin
                bit_cnt <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                shreg <= shreg_nxt;
                if (bit_cnt != BC_SAT) bit_cnt <= bit_cnt + 1'b1;
            end

            if (commit_ok) begin
                rx_out    <= shreg;
                frame_cnt <= frame_cnt + 1'b1;
            end

            if (commit_bad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_multi_lane_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_multi_lane_rx
//  Description : Self-checking bench for spi_multi_lane_rx. Two instances:
//                A = 2 lanes x 32 bits MSB first, B = 4 lanes x 16 bits LSB
//                first. Directed table, reset-mid-frame sequence and random
//                frames checked against a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_multi_lane_rx;

    localparam int SS   = 2;
    localparam int HALF = SS + 2;   // SCK half period in clk cycles
    localparam int GAP  = SS + 3;   // minimum SSEL high time between frames
    localparam int LAT  = SS + 2;   // SSEL rise to rdy

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        en_v   [2];
    logic        sck_v  [2];
    logic        ssel_v [2];
    logic [1:0]  data_a = '0;
    logic [3:0]  data_b = '0;

    logic [63:0] rx_a, rx_b;
    logic        rdy_a, rdy_b, err_a, err_b;
    logic [15:0] fc_a, ec_a, fc_b, ec_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_multi_lane_rx #(.NCH(2), .W(32), .SYNC_STAGES(SS), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .en(en_v[0]), .SCK(sck_v[0]), .SSEL(ssel_v[0]),
        .DATA_IN(data_a), .rx_out(rx_a), .rdy(rdy_a), .frame_err(err_a),
        .frame_cnt(fc_a), .err_cnt(ec_a)
    );

    spi_multi_lane_rx #(.NCH(4), .W(16), .SYNC_STAGES(SS), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .en(en_v[1]), .SCK(sck_v[1]), .SSEL(ssel_v[1]),
        .DATA_IN(data_b), .rx_out(rx_b), .rdy(rdy_b), .frame_err(err_b),
        .frame_cnt(fc_b), .err_cnt(ec_b)
    );

    function automatic logic [63:0] get_rx(input bit wh);  return wh ? rx_b  : rx_a;  endfunction
    function automatic logic        get_rdy(input bit wh); return wh ? rdy_b : rdy_a; endfunction
    function automatic logic        get_err(input bit wh); return wh ? err_b : err_a; endfunction
    function automatic logic [15:0] get_fc(input bit wh);  return wh ? fc_b  : fc_a;  endfunction
    function automatic logic [15:0] get_ec(input bit wh);  return wh ? ec_b  : ec_a;  endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives nbits SCK pulses; bits beyond the lane width are zero.
    task automatic send_bits(input bit wh, input int nbits, input logic [63:0] data);
        int w, nch, pos;
        logic b;
        w   = wh ? 16 : 32;
        nch = wh ? 4 : 2;
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < nch; k++) begin
                if (i >= w) b = 1'b0;
                else begin
                    pos = wh ? i : (w - 1 - i);
                    b   = data[6'(k*w + pos)];
                end
                if (wh) data_b[2'(k)] = b;
                else    data_a[1'(k)] = b;
            end
            cyc(HALF);
            sck_v[wh] = 1'b1;
            cyc(HALF);
            sck_v[wh] = 1'b0;
        end
    endtask

    task automatic run_frame(input bit wh, input bit en_i, input int nbits, input logic [63:0] data,
                             output int n_rdy, output int n_err, output int lat);
        en_v[wh]   = en_i;
        ssel_v[wh] = 1'b0;
        cyc(HALF);
        send_bits(wh, nbits, data);
        cyc(HALF);
        ssel_v[wh] = 1'b1;
        n_rdy = 0;
        n_err = 0;
        lat   = -1;
        for (int c = 1; c <= GAP; c++) begin
            cyc(1);
            if (get_rdy(wh)) begin
                n_rdy++;
                if (lat < 0) lat = c;
            end
            if (get_err(wh)) n_err++;
        end
    endtask

    task automatic check_frame(input string tag, input bit wh, input int n_rdy, input int n_err,
                               input int lat, input bit exp_rdy, input bit exp_err,
                               input logic [63:0] exp_rx, input logic [15:0] exp_fc,
                               input logic [15:0] exp_ec);
        chk({tag, ".rdy_pulses"}, 64'(n_rdy), exp_rdy ? 64'd1 : 64'd0);
        chk({tag, ".err_pulses"}, 64'(n_err), exp_err ? 64'd1 : 64'd0);
        if (exp_rdy) chk({tag, ".rdy_latency"}, 64'(lat), 64'(LAT));
        chk({tag, ".rx_out"},    get_rx(wh),         exp_rx);
        chk({tag, ".frame_cnt"}, 64'(get_fc(wh)),    64'(exp_fc));
        chk({tag, ".err_cnt"},   64'(get_ec(wh)),    64'(exp_ec));
    endtask

    // rx_out may only change together with rdy; rdy and frame_err exclusive
    logic [63:0] prev_rx_a = '0, prev_rx_b = '0;
    bit viol_rx_a = 1'b0, viol_rx_b = 1'b0, viol_both = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_a !== prev_rx_a && !rdy_a) viol_rx_a = 1'b1;
            if (rx_b !== prev_rx_b && !rdy_b) viol_rx_b = 1'b1;
            if ((rdy_a && err_a) || (rdy_b && err_b)) viol_both = 1'b1;
        end
        prev_rx_a = rx_a;
        prev_rx_b = rx_b;
    end

    typedef struct {
        bit          wh;
        bit          en;
        int          nbits;
        logic [63:0] data;
        bit          exp_rdy;
        bit          exp_err;
        logic [63:0] exp_rx;
        logic [15:0] exp_fc;
        logic [15:0] exp_ec;
    } vec_t;

    vec_t        tbl [7];
    logic [63:0] m_rx [2];
    logic [15:0] m_fc [2];
    logic [15:0] m_ec [2];

    initial begin
        int nr, ne, lt, cnt_r, cnt_e;
        bit wh, e, exp_r, exp_e;
        int w, nb, sel;
        logic [63:0] d;

        tbl[0] = '{1'b0, 1'b1, 32, 64'h42A00000_3F800000, 1'b1, 1'b0, 64'h42A00000_3F800000, 16'd1, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 31, 64'h01234567_89ABCDEF, 1'b0, 1'b1, 64'h42A00000_3F800000, 16'd1, 16'd1};
        tbl[2] = '{1'b0, 1'b1, 33, 64'hFEDCBA98_76543210, 1'b0, 1'b1, 64'h42A00000_3F800000, 16'd1, 16'd2};
        tbl[3] = '{1'b0, 1'b0, 32, 64'h55555555_AAAAAAAA, 1'b0, 1'b0, 64'h42A00000_3F800000, 16'd1, 16'd2};
        tbl[4] = '{1'b0, 1'b1, 32, 64'h00000000_00000001, 1'b1, 1'b0, 64'h00000000_00000001, 16'd2, 16'd2};
        tbl[5] = '{1'b0, 1'b1, 32, 64'h00000000_FFFFFFFF, 1'b1, 1'b0, 64'h00000000_FFFFFFFF, 16'd3, 16'd2};
        tbl[6] = '{1'b1, 1'b1, 16, 64'h0001_A5C3_8000_1234, 1'b1, 1'b0, 64'h0001_A5C3_8000_1234, 16'd1, 16'd0};

        for (int i = 0; i < 2; i++) begin
            en_v[i]   = 1'b1;
            sck_v[i]  = 1'b0;
            ssel_v[i] = 1'b1;
        end

        // reset state
        cyc(3);
        chk("reset.rx_out",    rx_a,        64'd0);
        chk("reset.rdy",       64'(rdy_a),  64'd0);
        chk("reset.frame_err", 64'(err_a),  64'd0);
        chk("reset.frame_cnt", 64'(fc_a),   64'd0);
        chk("reset.err_cnt",   64'(ec_a),   64'd0);
        reset = 1'b0;
        cyc(GAP);

        // directed table; consecutive rows run with the minimum SSEL gap
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].wh, tbl[i].en, tbl[i].nbits, tbl[i].data, nr, ne, lt);
            check_frame($sformatf("tbl%0d", i), tbl[i].wh, nr, ne, lt, tbl[i].exp_rdy,
                        tbl[i].exp_err, tbl[i].exp_rx, tbl[i].exp_fc, tbl[i].exp_ec);
        end

        // reset after 16 bits of a frame aborts it and clears everything
        en_v[0]   = 1'b1;
        ssel_v[0] = 1'b0;
        cyc(HALF);
        send_bits(1'b0, 16, 64'hFFFF0000_FFFF0000);
        reset     = 1'b1;
        ssel_v[0] = 1'b1;
        data_a    = '0;
        cyc(3);
        reset = 1'b0;
        chk("midreset.rx_a",  rx_a,       64'd0);
        chk("midreset.fc_a",  64'(fc_a),  64'd0);
        chk("midreset.ec_a",  64'(ec_a),  64'd0);
        chk("midreset.rx_b",  rx_b,       64'd0);
        chk("midreset.fc_b",  64'(fc_b),  64'd0);
        cnt_r = 0;
        cnt_e = 0;
        for (int c = 0; c < 2 * GAP; c++) begin
            cyc(1);
            if (rdy_a) cnt_r++;
            if (err_a) cnt_e++;
        end
        chk("midreset.quiet_rdy", 64'(cnt_r), 64'd0);
        chk("midreset.quiet_err", 64'(cnt_e), 64'd0);
        run_frame(1'b0, 1'b1, 32, 64'h9ABCDEF0_12345678, nr, ne, lt);
        check_frame("postreset", 1'b0, nr, ne, lt, 1'b1, 1'b0, 64'h9ABCDEF0_12345678, 16'd1, 16'd0);

        // random frames against the frame-level model
        m_rx[0] = 64'h9ABCDEF0_12345678; m_fc[0] = 16'd1; m_ec[0] = 16'd0;
        m_rx[1] = 64'd0;                 m_fc[1] = 16'd0; m_ec[1] = 16'd0;
        for (int r = 0; r < 40; r++) begin
            wh  = 1'($urandom_range(0, 1));
            e   = ($urandom_range(0, 7) != 0);
            w   = wh ? 16 : 32;
            sel = int'($urandom_range(0, 6));
            case (sel)
                0, 1, 2: nb = w;
                3:       nb = w - 1;
                4:       nb = w + 1;
                5:       nb = w + 2;
                default: nb = 0;
            endcase
            d = {$urandom, $urandom};
            exp_r = e && (nb == w);
            exp_e = e && (nb != w);
            if (exp_r) begin
                m_rx[wh] = d;
                m_fc[wh] = m_fc[wh] + 16'd1;
            end
            if (exp_e && m_ec[wh] != 16'hFFFF) m_ec[wh] = m_ec[wh] + 16'd1;
            run_frame(wh, e, nb, d, nr, ne, lt);
            check_frame($sformatf("rnd%0d", r), wh, nr, ne, lt, exp_r, exp_e,
                        m_rx[wh], m_fc[wh], m_ec[wh]);
        end

        chk("rx_a_stable_without_rdy", 64'(viol_rx_a), 64'd0);
        chk("rx_b_stable_without_rdy", 64'(viol_rx_b), 64'd0);
        chk("rdy_err_exclusive",       64'(viol_both), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got time limit expired, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
